// File: rtl/junction_turn_sequencer.sv
// Junction manoeuvre sequencer: drives the H-bridge through CLEAR/TURN/SETTLE using encoder feedback.
// Optional encoder glitch filter enabled by defining JTS_ENC_DEBOUNCE_EN.
module junction_turn_sequencer #(
  parameter int CNT_W           = 16,
  parameter int CLEAR_PULSES    = 20,
  parameter int TURN90_PULSES   = 40,
  parameter int TURN180_PULSES  = 80,
  parameter int SETTLE_CYCLES   = 2_500_000,
  parameter int TIMEOUT_CYCLES  = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] dir,
  input  logic       abort,
  input  logic       shaftPulseL,
  input  logic       shaftPulseR,
  input  logic       pwmDrive,
  input  logic       pwmTurn,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic       hbIn1,
  output logic       hbIn2,
  output logic       hbIn3,
  output logic       hbIn4,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CLR_T  = CNT_W'(CLEAR_PULSES);
  localparam logic [CNT_W-1:0] T90_T  = CNT_W'(TURN90_PULSES);
  localparam logic [CNT_W-1:0] T180_T = CNT_W'(TURN180_PULSES);
  localparam logic [WD_W-1:0]  WD_MAX = {WD_W{1'b1}};

  localparam logic [2:0] D_STRAIGHT = 3'b000;
  localparam logic [2:0] D_LEFT     = 3'b001;
  localparam logic [2:0] D_RIGHT    = 3'b010;
  localparam logic [2:0] D_BACK     = 3'b011;

  localparam logic [3:0] IN_FWD   = 4'b0110;
  localparam logic [3:0] IN_PIVL  = 4'b1010;
  localparam logic [3:0] IN_PIVR  = 4'b0101;
  localparam logic [3:0] IN_BRAKE = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_TURN, S_SETTLE, S_DONE, S_HALT, S_FAULT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c,
                                               input logic             inc,
                                               input logic [CNT_W-1:0] tgt);
    if (inc && (c < tgt)) return c + 1'b1;
    return c;
  endfunction

  function automatic logic [WD_W-1:0] sat_wd(input logic [WD_W-1:0] w);
    if (w == WD_MAX) return w;
    return w + 1'b1;
  endfunction

  // Encoder stage p0/p1: two-flop synchronizer; bit 0 = left, bit 1 = right
  logic [1:0] enc_p0_q, enc_p1_q, lvl_prev_q, enc_lvl, enc_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_p0_q   <= '0;
      enc_p1_q   <= '0;
      lvl_prev_q <= '0;
    end else begin
      enc_p0_q   <= {shaftPulseR, shaftPulseL};
      enc_p1_q   <= enc_p0_q;
      lvl_prev_q <= enc_lvl;
    end
  end

`ifdef JTS_ENC_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  // Filter stage: level is accepted only after staying different for the whole window
  logic [1:0]           filt_q, filt_d;
  logic [1:0][DB_W-1:0] db_q, db_d;

  always_comb begin
    filt_d = filt_q;
    db_d   = db_q;
    for (int i = 0; i < 2; i++) begin
      if (enc_p1_q[i] == filt_q[i]) begin
        db_d[i] = '0;
      end else if (int'(db_q[i]) + 1 >= DEBOUNCE_CYCLES) begin
        filt_d[i] = enc_p1_q[i];
        db_d[i]   = '0;
      end else begin
        db_d[i] = db_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      db_q   <= '0;
    end else begin
      filt_q <= filt_d;
      db_q   <= db_d;
    end
  end

  assign enc_lvl = filt_q;
`else
  assign enc_lvl = enc_p1_q;
`endif

  // Edge stage: rising edge of the (possibly filtered) level, consumed by the counters
  assign enc_edge = enc_lvl & ~lvl_prev_q;

  state_t            state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [3:0]        in_q, in_d;
  logic              en_a_q, en_a_d, en_b_q, en_b_d;
  logic              busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic [CNT_W-1:0]  tgt_cur, tgt_next;
  logic              reach_l, reach_r;

  assign tgt_cur = (state_q == S_CLEAR) ? CLR_T : ((dir_q == D_BACK) ? T180_T : T90_T);
  assign reach_l = (cnt_l_q >= tgt_cur);
  assign reach_r = (cnt_r_q >= tgt_cur);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_l_d = cnt_l_q;
    cnt_r_d = cnt_r_q;
    wd_d    = wd_q;
    st_d    = st_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          cnt_l_d = '0;
          cnt_r_d = '0;
          wd_d    = '0;
          case (dir)
            D_STRAIGHT, D_LEFT, D_RIGHT: state_d = S_CLEAR;
            D_BACK:                      state_d = S_TURN;
            default:                     state_d = S_HALT;
          endcase
        end
      end
      S_CLEAR, S_TURN: begin
        cnt_l_d = sat_cnt(cnt_l_q, enc_edge[0], tgt_cur);
        cnt_r_d = sat_cnt(cnt_r_q, enc_edge[1], tgt_cur);
        wd_d    = sat_wd(wd_q);
        if (reach_l && reach_r) begin
          cnt_l_d = '0;
          cnt_r_d = '0;
          wd_d    = '0;
          st_d    = '0;
          if (state_q == S_CLEAR && dir_q != D_STRAIGHT) state_d = S_TURN;
          else                                            state_d = S_SETTLE;
        end else if (int'(wd_q) + 1 >= TIMEOUT_CYCLES) begin
          state_d = S_FAULT;
        end
      end
      S_SETTLE: begin
        if (int'(st_q) + 1 >= SETTLE_CYCLES) state_d = S_DONE;
        else                                 st_d    = st_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including a simultaneous start, except a latched fault
    if (abort && state_q != S_FAULT) begin
      state_d = S_IDLE;
      cnt_l_d = '0;
      cnt_r_d = '0;
      wd_d    = '0;
      st_d    = '0;
    end
  end

  // Output stage: drive decoded from the next state so outputs are registered with it
  assign tgt_next = (state_d == S_CLEAR) ? CLR_T : ((dir_d == D_BACK) ? T180_T : T90_T);

  always_comb begin
    in_d   = IN_BRAKE;
    en_a_d = 1'b0;
    en_b_d = 1'b0;
    case (state_d)
      S_CLEAR: begin
        in_d   = IN_FWD;
        en_a_d = pwmDrive && (cnt_l_d < tgt_next);
        en_b_d = pwmDrive && (cnt_r_d < tgt_next);
      end
      S_TURN: begin
        in_d   = (dir_d == D_LEFT) ? IN_PIVL : IN_PIVR;
        en_a_d = pwmTurn && (cnt_l_d < tgt_next);
        en_b_d = pwmTurn && (cnt_r_d < tgt_next);
      end
      default: ;
    endcase
    busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      wd_q    <= '0;
      st_q    <= '0;
      in_q    <= IN_BRAKE;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_l_q <= cnt_l_d;
      cnt_r_q <= cnt_r_d;
      wd_q    <= wd_d;
      st_q    <= st_d;
      in_q    <= in_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign hbEnA = en_a_q;
  assign hbEnB = en_b_q;
  assign hbIn1 = in_q[3];
  assign hbIn2 = in_q[2];
  assign hbIn3 = in_q[1];
  assign hbIn4 = in_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_junction_turn_sequencer.sv
// Bench for junction_turn_sequencer: manoeuvre vector table with a phase/done scoreboard plus corner sequences.
`timescale 1ns/1ps
module tb_junction_turn_sequencer;

  localparam int SET = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] dir = 3'b000;
  logic       abort = 1'b0;
  logic       sl = 1'b0;
  logic       sr = 1'b0;
  logic       pwmDrive = 1'b1;
  logic       pwmTurn = 1'b1;
  logic       hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4, busy, done, fault;
  wire  [3:0] hb_in = {hbIn1, hbIn2, hbIn3, hbIn4};

  always #5 clk = ~clk;

  junction_turn_sequencer #(
    .CNT_W(16), .CLEAR_PULSES(3), .TURN90_PULSES(4), .TURN180_PULSES(8),
    .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(1000), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .shaftPulseL(sl), .shaftPulseR(sr), .pwmDrive(pwmDrive), .pwmTurn(pwmTurn),
    .hbEnA(hbEnA), .hbEnB(hbEnB), .hbIn1(hbIn1), .hbIn2(hbIn2), .hbIn3(hbIn3),
    .hbIn4(hbIn4), .busy(busy), .done(done), .fault(fault)
  );

  int errors = 0;
  int checks = 0;

  // kind 1: new drive code while busy (val = In code); kind 2: done pulse (val = brake cycles before it)
  typedef struct { int kind; int val; } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [2:0]  dir;
    int          np1;
    int          np2;
    int          nph;
    logic [11:0] ph;
    bit          halt;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val 0x%0h required none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event: got kind %0d val 0x%0h required kind %0d val 0x%0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  logic [4:0] prev_cur = 5'd0;
  logic       prev_done = 1'b0;
  int         run = 0;

  always @(negedge clk) begin
    if (prev_done) check("busy_after_done", busy, 0);
    if (busy === 1'b1 && {busy, hb_in} != prev_cur) observe(1, hb_in);
    if (done === 1'b1) observe(2, run);
    if (busy === 1'b1 && hb_in == 4'd0 && done === 1'b0) run++;
    else run = 0;
    prev_cur  = {busy, hb_in};
    prev_done = (done === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] d);
    dir   = d;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    dir   = ~d;
  endtask

  task automatic pulses(input int nl, input int nr);
    int n;
    n = (nl > nr) ? nl : nr;
    for (int i = 0; i < n; i++) begin
      sl = (i < nl);
      sr = (i < nr);
      tick(8);
      sl = 1'b0;
      sr = 1'b0;
      tick(8);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick(1);
      n++;
    end
    check({name, "_idle_timeout"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{3'b000, 3, 0, 2, 12'h600, 1'b0};
    vecs[1] = '{3'b001, 3, 4, 3, 12'h6A0, 1'b0};
    vecs[2] = '{3'b010, 3, 4, 3, 12'h650, 1'b0};
    vecs[3] = '{3'b011, 8, 0, 2, 12'h500, 1'b0};
    vecs[4] = '{3'b100, 0, 0, 1, 12'h000, 1'b1};
    vecs[5] = '{3'b110, 0, 0, 1, 12'h000, 1'b1};
    vecs[6] = '{3'b111, 0, 0, 1, 12'h000, 1'b1};

    tick(3);
    check("rst_enA", hbEnA, 0);
    check("rst_enB", hbEnB, 0);
    check("rst_in", hb_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 7; v++) begin
      for (int p = 0; p < vecs[v].nph; p++) expect_ev(1, int'(vecs[v].ph[11-4*p -: 4]));
      if (!vecs[v].halt) expect_ev(2, SET);
      do_start(vecs[v].dir);
      if (vecs[v].halt) begin
        pulses(3, 3);
        tick(40);
        check("halt_busy", busy, 1);
        check("halt_in", hb_in, 0);
        check("halt_en", {hbEnA, hbEnB}, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick(5);
      end else begin
        pulses(vecs[v].np1, vecs[v].np1);
        pulses(vecs[v].np2, vecs[v].np2);
        wait_idle("vec");
      end
      check("vec_queue_empty", exp_q.size(), 0);
      tick(3);
    end

    // LEFT with the left wheel finishing its pivot first
    expect_ev(1, 4'h6); expect_ev(1, 4'hA); expect_ev(1, 4'h0); expect_ev(2, SET);
    do_start(3'b001);
    check("first_drive_busy", busy, 1);
    check("first_drive_in", hb_in, 4'h6);
    check("first_drive_en", {hbEnA, hbEnB}, 2'b11);
    pulses(3, 3);
    check("turn_in", hb_in, 4'hA);
    pulses(4, 0);
    check("turn_enA_forced", hbEnA, 0);
    check("turn_enB_pwm", hbEnB, 1);
    pwmTurn = 1'b0;
    tick(2);
    check("turn_enB_pwm_low", hbEnB, 0);
    pwmTurn = 1'b1;
    tick(2);
    check("turn_enB_pwm_high", hbEnB, 1);
    dir   = 3'b000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("start_in_turn_in", hb_in, 4'hA);
    check("start_in_turn_busy", busy, 1);
    pulses(0, 4);
    wait_idle("left_seq");
    check("left_queue_empty", exp_q.size(), 0);
    tick(3);

    // reset in the middle of a BACK pivot
    expect_ev(1, 4'h5);
    do_start(3'b011);
    pulses(2, 2);
    check("mid_turn_in", hb_in, 4'h5);
    rst = 1'b1;
    tick(1);
    check("rst_mid_outputs", {hbEnA, hbEnB, hb_in, busy, done, fault}, 0);
    rst = 1'b0;
    tick(3);
    check("rst_mid_busy", busy, 0);
    check("rst_queue_empty", exp_q.size(), 0);

    // abort and start in the same IDLE cycle
    dir   = 3'b000;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    tick(3);
    check("abort_start_in", hb_in, 0);

    // watchdog: right-only pulses never finish CLEAR
    expect_ev(1, 4'h6);
    do_start(3'b010);
    pulses(0, 2);
    tick(958);
    check("wd_before_fault", fault, 0);
    check("wd_before_busy", busy, 1);
    tick(20);
    check("wd_fault", fault, 1);
    check("wd_busy", busy, 0);
    check("wd_outputs", {hbEnA, hbEnB, hb_in}, 0);
    do_start(3'b000);
    tick(3);
    check("wd_start_ignored", busy, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    check("wd_abort_ignored", fault, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("wd_rst_clears", fault, 0);
    check("wd_queue_empty", exp_q.size(), 0);
    tick(3);

`ifdef JTS_ENC_DEBOUNCE_EN
    // short glitches must not advance CLEAR
    expect_ev(1, 4'h6); expect_ev(1, 4'h0); expect_ev(2, SET);
    do_start(3'b000);
    for (int g = 0; g < 3; g++) begin
      sl = 1'b1;
      sr = 1'b1;
      tick(2);
      sl = 1'b0;
      sr = 1'b0;
      tick(10);
    end
    tick(10);
    check("glitch_still_clear", hb_in, 4'h6);
    check("glitch_enA", hbEnA, 1);
    pulses(3, 3);
    wait_idle("glitch");
    check("glitch_queue_empty", exp_q.size(), 0);
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
